// File: rtl/jstepper_pkg.sv
// Shared encodings for the step/phase timing source and its control-section decoder.
package jstepper_pkg;

    localparam logic [1:0] PH_E0  = 2'd0;
    localparam logic [1:0] PH_ES  = 2'd1;
    localparam logic [1:0] PH_E1  = 2'd2;
    localparam logic [1:0] PH_OFF = 2'd3;

    localparam int unsigned NSTEPS_DEFAULT = 6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/jstep_ring.sv
// One-hot step ring: load1 forces step 1, adv rotates left with wrap.
module jstep_ring #(
    parameter int unsigned NSTEPS = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adv,
    input  logic              load1,
    output logic [NSTEPS-1:0] step
);

    localparam logic [NSTEPS-1:0] STEP1 = {{(NSTEPS-1){1'b0}}, 1'b1};

    logic [NSTEPS-1:0] step_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= STEP1;
        end else if (load1) begin
            step_q <= STEP1;
        end else if (adv) begin
            step_q <= {step_q[NSTEPS-2:0], step_q[NSTEPS-1]};
        end
    end

    assign step = step_q;

endmodule

// File: rtl/jstepper.sv
// Four-phase clk_e/clk_s generator with a one-hot step sequence, all outputs registered
// from next-state decodes so they are glitch-free and mutually aligned.
module jstepper
    import jstepper_pkg::*;
#(
    parameter int unsigned NSTEPS = NSTEPS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              restart,
    output logic              clk_e,
    output logic              clk_s,
    output logic [NSTEPS-1:0] step,
    output logic [1:0]        phase,
    output logic              cycle_done
);

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic       pend_q, pend_d;
    logic       clk_e_q, clk_e_d;
    logic       clk_s_q, clk_s_d;
    logic       done_q, done_d;
    logic       adv, load1, running_d;

    jstep_ring #(
        .NSTEPS (NSTEPS)
    ) u_ring (
        .clk   (clk),
        .reset (reset),
        .adv   (adv),
        .load1 (load1),
        .step  (step)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pend_d  = pend_q;
        adv     = 1'b0;
        load1   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                phase_d = PH_E0;
                load1   = restart;
                if (run) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (phase_q == PH_OFF) begin
                    // Cycle boundary: only place step, restart and run take effect.
                    phase_d = PH_E0;
                    pend_d  = 1'b0;
                    if (pend_q || restart) load1 = 1'b1;
                    else                   adv   = 1'b1;
                    if (!run) state_d = ST_IDLE;
                end else begin
                    phase_d = phase_q + 2'd1;
                    if (restart) pend_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = PH_E0;
            end
        endcase

        running_d = (state_d == ST_RUN);
        clk_e_d   = running_d && (phase_d != PH_OFF);
        clk_s_d   = running_d && (phase_d == PH_ES);
        // Step cannot change on the edge entering PH_OFF, so the current step is the next one.
        done_d    = running_d && (phase_d == PH_OFF) && step[NSTEPS-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= PH_E0;
            pend_q  <= 1'b0;
            clk_e_q <= 1'b0;
            clk_s_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            clk_e_q <= clk_e_d;
            clk_s_q <= clk_s_d;
            done_q  <= done_d;
        end
    end

    assign clk_e      = clk_e_q;
    assign clk_s      = clk_s_q;
    assign phase      = phase_q;
    assign cycle_done = done_q;

endmodule
